// File: rtl/pc_fetch_unit.sv
// Program-counter fetch unit: issues instruction-memory reads, presents fetched words downstream, redirects on taken jumps.
// Optional macro PC_FETCH_BRANCH_COUNT_EN adds a saturating 16-bit br_count output.
module pc_fetch_unit #(
  parameter int unsigned          PC_W     = 32,
  parameter logic [PC_W-1:0]      RESET_PC = '0,
  parameter int unsigned          PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            jmp_taken,
  input  logic [PC_W-1:0] jmp_target,
  input  logic            stall,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [PC_W-1:0] instr_in,
  output logic [PC_W-1:0] instr_out,
  output logic [PC_W-1:0] instr_pc,
  output logic            instr_valid,
  output logic            flush
`ifdef PC_FETCH_BRANCH_COUNT_EN
  ,
  output logic [15:0]     br_count
`endif
);

  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            imem_req_q, imem_req_d;
  logic [PC_W-1:0] imem_addr_q, imem_addr_d;
  logic [PC_W-1:0] instr_out_q, instr_out_d;
  logic [PC_W-1:0] instr_pc_q, instr_pc_d;
  logic            instr_valid_q, instr_valid_d;
  logic            flush_q, flush_d;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    imem_req_d    = imem_req_q;
    imem_addr_d   = imem_addr_q;
    instr_out_d   = instr_out_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    flush_d       = 1'b0;

    unique case (state_q)
      // FETCH with imem_req_q=0 is the issue cycle; with imem_req_q=1 it waits for the ack.
      FETCH: begin
        if (jmp_taken) begin
          pc_d          = jmp_target;
          flush_d       = 1'b1;
          instr_valid_d = 1'b0;
          if (imem_req_q && !imem_ack) begin
            state_d = DROP;
          end else begin
            imem_req_d = 1'b0;
            state_d    = FETCH;
          end
        end else if (!imem_req_q) begin
          imem_req_d  = 1'b1;
          imem_addr_d = pc_q;
        end else if (imem_ack) begin
          instr_out_d   = instr_in;
          instr_pc_d    = imem_addr_q;
          instr_valid_d = 1'b1;
          pc_d          = pc_q + PC_W'(PC_STEP);
          imem_req_d    = 1'b0;
          state_d       = HOLD;
        end
      end
      HOLD: begin
        if (jmp_taken) begin
          pc_d          = jmp_target;
          flush_d       = 1'b1;
          instr_valid_d = 1'b0;
          state_d       = FETCH;
        end else if (!stall) begin
          instr_valid_d = 1'b0;
          state_d       = FETCH;
        end
      end
      DROP: begin
        if (jmp_taken) begin
          pc_d          = jmp_target;
          flush_d       = 1'b1;
          instr_valid_d = 1'b0;
        end
        // A jump landing on the same cycle as the ack still retires the stale read, so we never wait for a second ack.
        if (imem_ack) begin
          imem_req_d = 1'b0;
          state_d    = FETCH;
        end
      end
      default: begin
        imem_req_d = 1'b0;
        state_d    = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= '0;
      instr_out_q   <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      flush_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      imem_req_q    <= imem_req_d;
      imem_addr_q   <= imem_addr_d;
      instr_out_q   <= instr_out_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      flush_q       <= flush_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign instr_out   = instr_out_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign flush       = flush_q;

`ifdef PC_FETCH_BRANCH_COUNT_EN
  logic [15:0] br_count_q, br_count_d;

  always_comb begin
    br_count_d = br_count_q;
    if (jmp_taken && (br_count_q != '1)) begin
      br_count_d = br_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      br_count_q <= '0;
    end else begin
      br_count_q <= br_count_d;
    end
  end

  assign br_count = br_count_q;
`endif

endmodule
